canny_frame_source: RTL and testbench

Parametrised, synthesizable pixel-stream source for the canny edge-detection pipeline, replacing the fixed free-running clock/reset stimulus with a controllable frame generator. Produces IMG_W×IMG_H frames of selectable test patterns on a valid/ready stream with start-of-frame and end-of-line sidebands. Feeds the canny datapath's pixel input in bench and on-chip self-test builds.

---
 rtl/canny_frame_source.sv | 234 +++++++++++++++++++++++
 tb/tb_canny_frame_source.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/canny_frame_source.sv
// canny_frame_source
// ------------------
// Pixel-stream source for the canny edge-detection pipeline. It generates
// IMG_W x IMG_H frames of a selectable test pattern on a valid/ready stream,
// with start-of-frame and end-of-line sidebands. A run is NUM_FRAMES frames
// long, or endless when NUM_FRAMES is 0.
//
// Optional feature: define CANNY_SRC_HBLANK_EN to insert HBLANK idle cycles
// after every line except the final line of the run. Without the macro,
// lines are back-to-back and HBLANK is ignored.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   start      begin a run (sampled only while idle)
//   mode       pattern: 0 ramp, 1 checker, 2 constant, 3 LFSR (latched on start)
//   const_val  value for the constant pattern (latched on start)
//   m_valid    beat available
//   m_ready    sink accepts beat
//   m_data     pixel value
//   m_sof      beat is pixel (0,0) of a frame
//   m_eol      beat is the last pixel of a line
//   busy       run in progress
//   done       one-cycle pulse at the end of a run
//   frame_cnt  frames completed in this run (wraps at 2^16)
module canny_frame_source #(
    parameter int PIX_W      = 8,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int NUM_FRAMES = 1,
    parameter int HBLANK     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] const_val,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_sof,
    output logic             m_eol,
    output logic             busy,
    output logic             done,
    output logic [15:0]      frame_cnt
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST       = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST       = YW'(IMG_H - 1);
    localparam logic [15:0]   LFSR_SEED    = 16'hACE1;
    localparam logic [15:0]   FRAME_TARGET = 16'(NUM_FRAMES);
`ifdef CANNY_SRC_HBLANK_EN
    localparam int BW = (HBLANK > 1) ? $clog2(HBLANK) : 1;
`endif

    typedef enum logic [1:0] {IDLE, RUN, BLANK, DONE} state_t;

    state_t           state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [15:0]      frame_q, frame_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [1:0]       mode_q, mode_d;
    logic [PIX_W-1:0] const_q, const_d;
`ifdef CANNY_SRC_HBLANK_EN
    logic [BW-1:0]    blank_q, blank_d;
`endif

    logic             m_valid_q, m_valid_d;
    logic [PIX_W-1:0] m_data_q, m_data_d;
    logic             m_sof_q, m_sof_d;
    logic             m_eol_q, m_eol_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic             run_end;
    logic             feedback;

    // Pixel value for coordinate (px,py). Coordinates are widened so that
    // bit 3 of the checker exists even for narrow images.
    function automatic logic [PIX_W-1:0] pattern(
        input logic [1:0]       pmode,
        input logic [PIX_W-1:0] pconst,
        input logic [XW-1:0]    px,
        input logic [YW-1:0]    py,
        input logic [15:0]      plfsr
    );
        logic [31:0] xe;
        logic [31:0] ye;
        logic [31:0] sum;
        xe  = 32'(px);
        ye  = 32'(py);
        sum = xe + ye;
        case (pmode)
            2'd0:    pattern = sum[PIX_W-1:0];
            2'd1:    pattern = (xe[3] ^ ye[3]) ? '1 : '0;
            2'd2:    pattern = pconst;
            default: pattern = plfsr[PIX_W-1:0];
        endcase
    endfunction

    // Next-state logic. The registered outputs are derived from the next
    // state and next coordinates so that every output comes straight from a
    // flop and a stalled beat keeps its data because x/y/lfsr do not move.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        frame_d  = frame_q;
        lfsr_d   = lfsr_q;
        mode_d   = mode_q;
        const_d  = const_q;
`ifdef CANNY_SRC_HBLANK_EN
        blank_d  = blank_q;
`endif
        run_end  = 1'b0;
        accept   = m_valid_q && m_ready;
        // Fibonacci LFSR, taps 16,14,13,11 (bits 0,2,3,5 of a right shifter).
        feedback = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    mode_d  = mode;
                    const_d = const_val;
                    x_d     = '0;
                    y_d     = '0;
                    frame_d = '0;
                    lfsr_d  = LFSR_SEED;
                end
            end
            RUN: begin
                if (accept) begin
                    lfsr_d = {feedback, lfsr_q[15:1]};
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            frame_d = frame_q + 16'd1;
                            if ((NUM_FRAMES != 0) && (frame_d == FRAME_TARGET)) begin
                                run_end = 1'b1;
                            end
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                        if (run_end) begin
                            state_d = DONE;
                        end
`ifdef CANNY_SRC_HBLANK_EN
                        else if (HBLANK > 0) begin
                            state_d = BLANK;
                            blank_d = BW'(HBLANK - 1);
                        end
`endif
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            BLANK: begin
`ifdef CANNY_SRC_HBLANK_EN
                if (blank_q == '0) begin
                    state_d = RUN;
                end else begin
                    blank_d = blank_q - 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        m_valid_d = (state_d == RUN);
        busy_d    = (state_d == RUN) || (state_d == BLANK);
        done_d    = (state_d == DONE);
        m_data_d  = pattern(mode_d, const_d, x_d, y_d, lfsr_d);
        m_sof_d   = m_valid_d && (x_d == '0) && (y_d == '0);
        m_eol_d   = m_valid_d && (x_d == X_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            frame_q   <= '0;
            lfsr_q    <= LFSR_SEED;
            mode_q    <= '0;
            const_q   <= '0;
`ifdef CANNY_SRC_HBLANK_EN
            blank_q   <= '0;
`endif
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_sof_q   <= 1'b0;
            m_eol_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            frame_q   <= frame_d;
            lfsr_q    <= lfsr_d;
            mode_q    <= mode_d;
            const_q   <= const_d;
`ifdef CANNY_SRC_HBLANK_EN
            blank_q   <= blank_d;
`endif
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_sof_q   <= m_sof_d;
            m_eol_q   <= m_eol_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_sof     = m_sof_q;
    assign m_eol     = m_eol_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_canny_frame_source.sv
// Testbench for canny_frame_source. Two instances share one clock:
//   A: 4x2 image, one frame per run (directed test-plan runs + random runs)
//   B: 16x10 image, endless runs stopped by reset mid-second-frame
// Expected beats come from a pattern model and are queued per run; a monitor
// per instance pops and compares on every accepted beat.
module tb_canny_frame_source;

    localparam int PW = 8;
    localparam int AW = 4;
    localparam int AH = 2;
    localparam int BW = 16;
    localparam int BH = 10;
    localparam int HB = 2;
`ifdef CANNY_SRC_HBLANK_EN
    localparam int GAP = HB;
`else
    localparam int GAP = 0;
`endif

    typedef struct {
        logic [7:0] data;
        bit         sof;
        bit         eol;
        int         gap;
        bit         last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic          resetA, startA, readyA;
    logic [1:0]    modeA;
    logic [PW-1:0] constA;
    logic          validA, sofA, eolA, busyA, doneA;
    logic [PW-1:0] dataA;
    logic [15:0]   frameCntA;

    // Instance B signals
    logic          resetB, startB, readyB;
    logic [1:0]    modeB;
    logic [PW-1:0] constB;
    logic          validB, sofB, eolB, busyB, doneB;
    logic [PW-1:0] dataB;
    logic [15:0]   frameCntB;

    int total = 0;
    int bad   = 0;

    beat_t expA[$];
    beat_t expB[$];
    int    doneCntA = 0;
    int    expDoneA = 0;
    int    doneCntB = 0;
    int    acceptedB = 0;
    bit    randReadyA = 0;
    bit    randReadyB = 0;

    canny_frame_source #(
        .PIX_W(PW), .IMG_W(AW), .IMG_H(AH), .NUM_FRAMES(1), .HBLANK(HB)
    ) dutA (
        .clk(clk), .reset(resetA), .start(startA), .mode(modeA),
        .const_val(constA), .m_valid(validA), .m_ready(readyA),
        .m_data(dataA), .m_sof(sofA), .m_eol(eolA), .busy(busyA),
        .done(doneA), .frame_cnt(frameCntA)
    );

    canny_frame_source #(
        .PIX_W(PW), .IMG_W(BW), .IMG_H(BH), .NUM_FRAMES(0), .HBLANK(HB)
    ) dutB (
        .clk(clk), .reset(resetB), .start(startB), .mode(modeB),
        .const_val(constB), .m_valid(validB), .m_ready(readyB),
        .m_data(dataB), .m_sof(sofB), .m_eol(eolB), .busy(busyB),
        .done(doneB), .frame_cnt(frameCntB)
    );

    // Single comparison point: every check goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference LFSR: 16-bit Fibonacci register, taps 16,14,13,11.
    function automatic int lfsrNext(input int l);
        int fb;
        fb = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return (l >> 1) | (fb << 15);
    endfunction

    function automatic logic [7:0] pixel(input int mode, input int cval,
                                         input int x, input int y, input int l);
        case (mode)
            0:       return 8'((x + y) % 256);
            1:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
            2:       return 8'(cval);
            default: return 8'(l % 256);
        endcase
    endfunction

    // Queue one complete single-frame run for instance A.
    task automatic pushRunA(input int mode, input int cval);
        int    l;
        beat_t b;
        l = 16'hACE1;
        for (int y = 0; y < AH; y++) begin
            for (int x = 0; x < AW; x++) begin
                b.data = pixel(mode, cval, x, y, l);
                b.sof  = (x == 0 && y == 0);
                b.eol  = (x == AW - 1);
                b.gap  = (x == 0 && y > 0) ? GAP : 0;
                b.last = (x == AW - 1 && y == AH - 1);
                expA.push_back(b);
                l = lfsrNext(l);
            end
        end
    endtask

    // Queue several frames of an endless run for instance B.
    task automatic pushRunB(input int mode, input int cval, input int frames);
        int    l;
        beat_t b;
        l = 16'hACE1;
        for (int f = 0; f < frames; f++) begin
            for (int y = 0; y < BH; y++) begin
                for (int x = 0; x < BW; x++) begin
                    b.data = pixel(mode, cval, x, y, l);
                    b.sof  = (x == 0 && y == 0);
                    b.eol  = (x == BW - 1);
                    b.gap  = (x == 0 && !(f == 0 && y == 0)) ? GAP : 0;
                    b.last = 1'b0;
                    expB.push_back(b);
                    l = lfsrNext(l);
                end
            end
        end
    endtask

    // Monitor A: scoreboard compare, stall stability, blanking gap, done pulse.
    int         gapA = 0;
    bit         stallA = 0;
    bit         doneExpA = 0;
    logic [7:0] sdA;
    logic       ssA, seA;
    always @(negedge clk) begin
        beat_t b;
        if (resetA) begin
            gapA = 0; stallA = 0; doneExpA = 0;
        end else begin
            if (doneA) doneCntA++;
            if (doneExpA) begin
                checkOutput("A done pulse", doneA, 1);
                checkOutput("A busy at done", busyA, 0);
                checkOutput("A frame_cnt at done", frameCntA, 1);
                checkOutput("A valid at done", validA, 0);
                doneExpA = 0;
            end
            if (stallA) begin
                checkOutput("A stall valid", validA, 1);
                checkOutput("A stall data", dataA, sdA);
                checkOutput("A stall sof", sofA, ssA);
                checkOutput("A stall eol", eolA, seA);
            end
            if (validA && readyA) begin
                if (expA.size() == 0) begin
                    checkOutput("A unexpected beat", 1, 0);
                end else begin
                    b = expA.pop_front();
                    checkOutput("A data", dataA, b.data);
                    checkOutput("A sof", sofA, b.sof);
                    checkOutput("A eol", eolA, b.eol);
                    checkOutput("A gap", gapA, b.gap);
                    if (b.last) doneExpA = 1;
                end
                gapA = 0; stallA = 0;
            end else if (validA) begin
                stallA = 1; sdA = dataA; ssA = sofA; seA = eolA;
            end else begin
                stallA = 0;
                if (busyA) gapA++;
            end
        end
    end

    // Monitor B: same scoreboard without the done pulse (endless runs).
    int         gapB = 0;
    bit         stallB = 0;
    logic [7:0] sdB;
    logic       ssB, seB;
    always @(negedge clk) begin
        beat_t b;
        if (resetB) begin
            gapB = 0; stallB = 0;
        end else begin
            if (doneB) doneCntB++;
            if (stallB) begin
                checkOutput("B stall valid", validB, 1);
                checkOutput("B stall data", dataB, sdB);
                checkOutput("B stall sof", sofB, ssB);
                checkOutput("B stall eol", eolB, seB);
            end
            if (validB && readyB) begin
                acceptedB++;
                if (expB.size() == 0) begin
                    checkOutput("B unexpected beat", 1, 0);
                end else begin
                    b = expB.pop_front();
                    checkOutput("B data", dataB, b.data);
                    checkOutput("B sof", sofB, b.sof);
                    checkOutput("B eol", eolB, b.eol);
                    checkOutput("B gap", gapB, b.gap);
                end
                gapB = 0; stallB = 0;
            end else if (validB) begin
                stallB = 1; sdB = dataB; ssB = sofB; seB = eolB;
            end else begin
                stallB = 0;
                if (busyB) gapB++;
            end
        end
    end

    // Random backpressure when enabled.
    always @(posedge clk) begin
        #1;
        if (randReadyA) readyA = ($urandom % 4) != 0;
        if (randReadyB) readyB = ($urandom % 4) != 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One run on A: start, scramble mode/const afterwards, optionally poke
    // start while busy, then wait (bounded) for done.
    task automatic applyStimulus(input int mode, input int cval, input bit noisyStart,
                                 input bit startInDone);
        int cycles;
        pushRunA(mode, cval);
        expDoneA++;
        startA = 1; modeA = 2'(mode); constA = 8'(cval);
        tick();
        startA = 0;
        modeA = 2'($urandom); constA = 8'($urandom);
        checkOutput("A busy after start", busyA, 1);
        checkOutput("A frame_cnt cleared", frameCntA, 0);
        if (mode == 3 && readyA) checkOutput("A lfsr first beat", dataA, 8'hE1);
        cycles = 0;
        while (!doneA && cycles < 400) begin
            startA = noisyStart && busyA && (($urandom % 4) == 0);
            tick();
            cycles++;
        end
        startA = 0;
        if (!doneA) checkOutput("A run timeout", 0, 1);
        if (startInDone) begin
            startA = 1;
            tick();
            startA = 0;
            checkOutput("A start in DONE ignored busy", busyA, 0);
            tick();
            checkOutput("A start in DONE ignored valid", validA, 0);
            checkOutput("A frame_cnt holds", frameCntA, 1);
        end else begin
            tick();
        end
    endtask

    // One endless run on B, reset in the middle of the second frame.
    task automatic runB(input int mode, input int cval);
        int cycles;
        int target;
        expB.delete();
        acceptedB = 0;
        pushRunB(mode, cval, 3);
        startB = 1; modeB = 2'(mode); constB = 8'(cval);
        tick();
        startB = 0;
        modeB = 2'($urandom); constB = 8'($urandom);
        checkOutput("B sof after start", sofB, 1);
        target = BW * BH + BW * 3 + int'($urandom_range(0, 20));
        cycles = 0;
        while (acceptedB < target && cycles < 3000) begin
            tick();
            cycles++;
        end
        if (acceptedB < target) checkOutput("B run timeout", 0, 1);
        checkOutput("B frame_cnt mid frame 2", frameCntB, 1);
        resetB = 1;
        #1;
        checkOutput("B reset valid", validB, 0);
        checkOutput("B reset data", dataB, 0);
        checkOutput("B reset sof/eol", {sofB, eolB}, 0);
        checkOutput("B reset busy/done", {busyB, doneB}, 0);
        checkOutput("B reset frame_cnt", frameCntB, 0);
        tick();
        resetB = 0;
        expB.delete();
        tick();
    endtask

    initial begin
        resetA = 1; startA = 0; readyA = 1; modeA = 0; constA = 0;
        resetB = 1; startB = 0; readyB = 1; modeB = 0; constB = 0;
        #12;
        checkOutput("A reset outputs", {validA, sofA, eolA, busyA, doneA}, 0);
        checkOutput("A reset data", dataA, 0);
        checkOutput("A reset frame_cnt", frameCntA, 0);
        checkOutput("B reset outputs", {validB, sofB, eolB, busyB, doneB}, 0);
        tick();
        resetA = 0; resetB = 0;
        tick();

        $display("[TB] ramp 4x2, ready high");
        applyStimulus(0, 0, 0, 0);

        $display("[TB] ramp with 3-cycle stall on beat 2");
        fork
            applyStimulus(0, 0, 0, 0);
            begin
                repeat (3) tick();
                readyA = 0;
                repeat (3) tick();
                readyA = 1;
            end
        join

        $display("[TB] lfsr pattern");
        applyStimulus(3, 0, 0, 0);

        $display("[TB] start while busy and in DONE cycle");
        applyStimulus(0, 0, 1, 1);

        $display("[TB] random runs on A");
        randReadyA = 1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(int'($urandom % 4), int'($urandom % 256), 1, (i % 2) == 1);
        end
        randReadyA = 0;
        readyA = 1;
        tick();
        checkOutput("A done count", doneCntA, expDoneA);
        checkOutput("A queue drained", expA.size(), 0);

        $display("[TB] endless runs on B with mid-frame reset");
        randReadyB = 1;
        runB(1, 0);
        runB(0, 0);
        runB(3, 0);
        runB(2, int'($urandom % 256));
        randReadyB = 0;
        checkOutput("B never done", doneCntB, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
